locking_rr_arbiter: RTL and testbench
=====================================

LOCKING_RR_ARBITER -- requirements
Module: locking_rr_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default 4, number of requesters (any value >= 2; non-power-of-two legal).
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive cycles one owner holds the grant while others wait (>= 2).
REQ-003 Localparam INDEX_WIDTH = $clog2(NUM_REQUESTERS).
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 request  input  NUM_REQUESTERS  per-requester level request; bit i high = requester i wants the resource.
REQ-007 release_grant  input  1  current owner relinquishes the resource this cycle; ignored when grant_valid is 0.
REQ-008 grant_oh  output  NUM_REQUESTERS  registered one-hot grant; all zero when no owner.
REQ-009 grant_idx  output  INDEX_WIDTH  binary index of the set grant_oh bit; 0 when grant_valid is 0.
REQ-010 grant_valid  output  1  registered; high when grant_oh has exactly one bit set.
REQ-011 preempted  output  1  registered one-cycle pulse; owner revoked by hold timeout.

Function
REQ-012 States IDLE and OWNED; grant_valid is high exactly in OWNED.
REQ-013 Round-robin pointer (INDEX_WIDTH bits) names the highest-priority requester; priority descends pointer, pointer+1, ..., wrapping from NUM_REQUESTERS-1 to 0.
REQ-014 IDLE, request nonzero at edge k: winner = first set bit at/after pointer; grant_oh/grant_valid/grant_idx show winner after edge k; state -> OWNED; hold counter -> 0.
REQ-015 IDLE, request zero: outputs stay zero, pointer unchanged.
REQ-016 OWNED, release_grant high or request[owner] low at an edge: pointer -> owner+1 (wrap at NUM_REQUESTERS-1 to 0); if other requests pending, new winner granted at same edge with no idle bubble, else -> IDLE with grant_oh zero.
REQ-017 During handoff, departing owner's request bit is excluded from the arbitration at that edge.
REQ-018 OWNED, no release: hold counter increments each cycle while any other requester is pending; resets to 0 while owner is sole requester.
REQ-019 Hold counter reaching MAX_HOLD-1 with another requester pending: at next edge grant moves to next requester after owner (per REQ-013), pointer -> owner+1, preempted pulses one cycle, counter -> 0.
REQ-020 Release and timeout at same edge: treated as release; preempted stays low.
REQ-021 Hold counter width $clog2(MAX_HOLD)+1; never exceeds MAX_HOLD-1.
REQ-022 grant_oh never has more than one bit set; grant_idx consistent with grant_oh in the same cycle.

Reset
REQ-023 While reset low: state IDLE, pointer 0, hold counter 0, grant_oh 0, grant_idx 0, grant_valid 0, preempted 0, asynchronously.
REQ-024 Reset asserted mid-ownership drops the grant immediately without a preempted pulse; first grant after reset release follows REQ-014 with pointer 0.

Structure
REQ-025 State enum and hold counter are local to the module; no shared package additions.
REQ-026 grant_idx produced by one instance of existing oh_to_idx (NUM_SIGNALS=NUM_REQUESTERS, DIRECTION "LSB0") driven by grant_oh.
REQ-027 Winner selection is combinational rotate-priority logic; only state, pointer, counter, grant_oh, preempted are flopped.

Verification
REQ-028 NUM_REQUESTERS=7, request=7'h7F, release_grant pulsed every 2nd cycle -> grant_idx sequence 0,1,2,3,4,5,6,0 (wrap over non-power-of-two).
REQ-029 request=4'b0100 from reset -> grant_oh 4'b0100, grant_idx 2 one cycle later; deassert request -> grant_valid 0 next cycle.
REQ-030 MAX_HOLD=8, request=4'b0011, no release -> requester 0 owns 8 cycles, then grant_idx 1 and preempted pulses once.
REQ-031 Owner 1 releases while request=4'b1010 -> grant_idx 3 at same edge, no cycle with grant_valid 0.
REQ-032 Sole requester 2 held 20 cycles, no release -> grant persists, preempted never asserts.
REQ-033 reset low while owner 3 granted -> all outputs 0 immediately; after reset high with request=4'b1111 -> grant_idx 0.

Source files
------------

// File: rtl/locking_rr_arbiter_pkg.sv
// Shared constants for the locking round-robin arbiter slice.
// Holds the default sizing and the index-ordering tag used by the
// one-hot to binary index converter.
package locking_rr_arbiter_pkg;

    localparam int    ARB_DEFAULT_REQUESTERS = 4;
    localparam int    ARB_DEFAULT_MAX_HOLD   = 8;
    localparam string OH_DIR_LSB0            = "LSB0";
    localparam string OH_DIR_MSB0            = "MSB0";

endpackage

// File: rtl/oh_to_idx.sv
// One-hot to binary index converter.
// With DIRECTION "LSB0" bit 0 maps to index 0; with "MSB0" the highest
// bit maps to index 0. An all-zero input produces index 0.
module oh_to_idx
    import locking_rr_arbiter_pkg::*;
#(
    parameter int    NUM_SIGNALS = 4,
    parameter string DIRECTION   = OH_DIR_LSB0,
    localparam int   IDX_WIDTH   = $clog2(NUM_SIGNALS)
) (
    input  logic [NUM_SIGNALS-1:0] oh_i,
    output logic [IDX_WIDTH-1:0]   idx_o
);

    localparam bit MSB_FIRST = (DIRECTION == OH_DIR_MSB0);

    // OR together the index of every set bit; for a legal one-hot input
    // this is exactly the index of the single set bit.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (oh_i[i]) begin
                idx_o = idx_o | (MSB_FIRST ? IDX_WIDTH'(NUM_SIGNALS - 1 - i)
                                           : IDX_WIDTH'(i));
            end
        end
    end

endmodule

// File: rtl/locking_rr_arbiter.sv
// Locking round-robin arbiter.
// An owner keeps the grant until it releases, drops its request, or is
// revoked after holding it for MAX_HOLD cycles while others wait. The
// rotating pointer always names the requester just after the last owner,
// so every requester gets a turn, including for non-power-of-two counts.
module locking_rr_arbiter
    import locking_rr_arbiter_pkg::*;
#(
    parameter int  NUM_REQUESTERS = ARB_DEFAULT_REQUESTERS,
    parameter int  MAX_HOLD       = ARB_DEFAULT_MAX_HOLD,
    localparam int INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      release_grant,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [INDEX_WIDTH-1:0]    grant_idx,
    output logic                      grant_valid,
    output logic                      preempted
);

    localparam int HOLD_WIDTH = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arbState_e;

    arbState_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0]    ptr_q, ptr_d;
    logic [HOLD_WIDTH-1:0]     holdCnt_q, holdCnt_d;
    logic [NUM_REQUESTERS-1:0] grant_q, grant_d;
    logic                      preempted_q, preempted_d;

    logic [INDEX_WIDTH-1:0]    ownerIdx;
    logic [INDEX_WIDTH-1:0]    afterOwner;
    logic [NUM_REQUESTERS-1:0] othersReq;
    logic                      ownerStillWants;
    logic                      ownerLeaves;
    logic                      holdExpired;

    // Rotate-priority pick: first set bit at or after start, wrapping from
    // the top requester back to requester 0.
    function automatic logic [NUM_REQUESTERS-1:0] rotatePick(
        input logic [NUM_REQUESTERS-1:0] reqVec,
        input logic [INDEX_WIDTH-1:0]    start
    );
        logic [NUM_REQUESTERS-1:0] pick;
        logic                      found;
        logic [INDEX_WIDTH-1:0]    posIdx;
        int                        pos;
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < NUM_REQUESTERS; off++) begin
            pos = int'(start) + off;
            if (pos >= NUM_REQUESTERS) begin
                pos = pos - NUM_REQUESTERS;
            end
            posIdx = INDEX_WIDTH'(pos);
            if (!found && reqVec[posIdx]) begin
                pick[posIdx] = 1'b1;
                found        = 1'b1;
            end
        end
        return pick;
    endfunction

    // The binary owner index comes from the registered one-hot grant, so the
    // published index and the internal owner index are always the same value.
    oh_to_idx #(
        .NUM_SIGNALS (NUM_REQUESTERS),
        .DIRECTION   (OH_DIR_LSB0)
    ) u_grant_idx (
        .oh_i  (grant_q),
        .idx_o (ownerIdx)
    );

    // Handoff qualifiers: who else is waiting, whether the owner is leaving,
    // and where the pointer moves once the current owner is done.
    always_comb begin
        othersReq       = request & ~grant_q;
        ownerStillWants = |(request & grant_q);
        ownerLeaves     = release_grant || !ownerStillWants;
        holdExpired     = (holdCnt_q == HOLD_WIDTH'(MAX_HOLD - 1));
        if (ownerIdx == INDEX_WIDTH'(NUM_REQUESTERS - 1)) begin
            afterOwner = '0;
        end else begin
            afterOwner = ownerIdx + INDEX_WIDTH'(1);
        end
    end

    // Next-state decision: grant from idle, hand off on release (excluding
    // the departing owner), revoke on hold timeout, otherwise keep counting.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        holdCnt_d   = holdCnt_q;
        grant_d     = grant_q;
        preempted_d = 1'b0;
        case (state_q)
            IDLE: begin
                holdCnt_d = '0;
                if (|request) begin
                    grant_d = rotatePick(request, ptr_q);
                    state_d = OWNED;
                end else begin
                    grant_d = '0;
                end
            end
            OWNED: begin
                if (ownerLeaves) begin
                    ptr_d     = afterOwner;
                    holdCnt_d = '0;
                    if (|othersReq) begin
                        grant_d = rotatePick(othersReq, afterOwner);
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if (|othersReq) begin
                    if (holdExpired) begin
                        ptr_d       = afterOwner;
                        grant_d     = rotatePick(othersReq, afterOwner);
                        preempted_d = 1'b1;
                        holdCnt_d   = '0;
                    end else begin
                        holdCnt_d = holdCnt_q + HOLD_WIDTH'(1);
                    end
                end else begin
                    holdCnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = '0;
                holdCnt_d = '0;
            end
        endcase
    end

    // State register; reset clears ownership at once with no preempt pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            holdCnt_q   <= '0;
            grant_q     <= '0;
            preempted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            holdCnt_q   <= holdCnt_d;
            grant_q     <= grant_d;
            preempted_q <= preempted_d;
        end
    end

    assign grant_oh    = grant_q;
    assign grant_idx   = ownerIdx;
    assign grant_valid = (state_q == OWNED);
    assign preempted   = preempted_q;

endmodule

// File: tb/tb_locking_rr_arbiter.sv
// Scoreboard bench for the locking round-robin arbiter.
// A 4-requester and a 7-requester instance share clock and reset. Each
// stimulus call pushes the hand-computed response expected after the next
// clock edge; a monitor pops entries tagged with that edge and compares.
module tb_locking_rr_arbiter;

    logic       clk;
    logic       reset;

    logic [3:0] req4;
    logic       rel4;
    logic [3:0] grantOh4;
    logic [1:0] grantIdx4;
    logic       grantValid4;
    logic       preempted4;

    logic [6:0] req7;
    logic       rel7;
    logic [6:0] grantOh7;
    logic [2:0] grantIdx7;
    logic       grantValid7;
    logic       preempted7;

    int checks   = 0;
    int errors   = 0;
    int cycleCnt = 0;

    typedef struct {
        int         sel;
        int         cyc;
        logic [6:0] oh;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
        string      name;
    } expect_t;

    expect_t sbQueue[$];

    locking_rr_arbiter #(
        .NUM_REQUESTERS (4),
        .MAX_HOLD       (8)
    ) dut4 (
        .clk           (clk),
        .reset         (reset),
        .request       (req4),
        .release_grant (rel4),
        .grant_oh      (grantOh4),
        .grant_idx     (grantIdx4),
        .grant_valid   (grantValid4),
        .preempted     (preempted4)
    );

    locking_rr_arbiter #(
        .NUM_REQUESTERS (7),
        .MAX_HOLD       (8)
    ) dut7 (
        .clk           (clk),
        .reset         (reset),
        .request       (req7),
        .release_grant (rel7),
        .grant_oh      (grantOh7),
        .grant_idx     (grantIdx7),
        .grant_valid   (grantValid7),
        .preempted     (preempted7)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to tag which edge each expectation belongs to.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Compare one DUT's outputs against an expected tuple.
    task automatic checkOutput(input string name, input int sel,
                               input logic [6:0] expOh, input logic [2:0] expIdx,
                               input logic expValid, input logic expPre);
        logic [6:0] actOh;
        logic [2:0] actIdx;
        logic       actValid;
        logic       actPre;
        if (sel == 0) begin
            actOh    = {3'b000, grantOh4};
            actIdx   = {1'b0, grantIdx4};
            actValid = grantValid4;
            actPre   = preempted4;
        end else begin
            actOh    = grantOh7;
            actIdx   = grantIdx7;
            actValid = grantValid7;
            actPre   = preempted7;
        end
        checks++;
        if (actOh !== expOh || actIdx !== expIdx || actValid !== expValid || actPre !== expPre) begin
            errors++;
            $display("[TB] FAIL %s (t=%0t): got oh=%b idx=%0d valid=%b pre=%b, expected oh=%b idx=%0d valid=%b pre=%b",
                     name, $time, actOh, actIdx, actValid, actPre, expOh, expIdx, expValid, expPre);
        end
    endtask

    // Drive inputs on the falling edge and queue the response expected after
    // the following rising edge.
    task automatic applyStimulus(input int sel, input logic [6:0] req, input logic rel,
                                 input logic [6:0] expOh, input logic [2:0] expIdx,
                                 input logic expValid, input logic expPre, input string name);
        expect_t e;
        @(negedge clk);
        if (sel == 0) begin
            req4 = req[3:0];
            rel4 = rel;
        end else begin
            req7 = req;
            rel7 = rel;
        end
        e.sel   = sel;
        e.cyc   = cycleCnt + 1;
        e.oh    = expOh;
        e.idx   = expIdx;
        e.valid = expValid;
        e.pre   = expPre;
        e.name  = name;
        sbQueue.push_back(e);
    endtask

    // Monitor: shortly after each rising edge, pop and check every
    // expectation tagged for this edge; anything older was missed.
    always @(posedge clk) begin
        #2;
        while (sbQueue.size() > 0 && sbQueue[0].cyc <= cycleCnt) begin
            expect_t e;
            e = sbQueue.pop_front();
            if (e.cyc < cycleCnt) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: expectation for edge %0d not checked, now edge %0d",
                         e.name, e.cyc, cycleCnt);
            end else begin
                checkOutput(e.name, e.sel, e.oh, e.idx, e.valid, e.pre);
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        int own;
        reset = 1'b0;
        req4  = '0;
        rel4  = 1'b0;
        req7  = '0;
        rel7  = 1'b0;

        #3;
        checkOutput("reset4", 0, 7'h00, 3'd0, 1'b0, 1'b0);
        checkOutput("reset7", 1, 7'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // Single requester 2 granted, then dropped (pointer -> 3).
        applyStimulus(0, 7'b0100, 1'b0, 7'b0100, 3'd2, 1'b1, 1'b0, "single_grant");
        applyStimulus(0, 7'b0000, 1'b0, 7'b0000, 3'd0, 1'b0, 1'b0, "single_drop");

        // Requesters 0 and 1, no release: 0 owns 8 cycles, then preempted.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 7'b0011, 1'b0, 7'b0001, 3'd0, 1'b1, 1'b0, "hold_owner0");
        end
        applyStimulus(0, 7'b0011, 1'b0, 7'b0010, 3'd1, 1'b1, 1'b1, "preempt_to1");
        applyStimulus(0, 7'b0011, 1'b0, 7'b0010, 3'd1, 1'b1, 1'b0, "preempt_one_pulse");

        // Owner 1 releases with 1 and 3 requesting: 3 granted at same edge.
        applyStimulus(0, 7'b1010, 1'b1, 7'b1000, 3'd3, 1'b1, 1'b0, "handoff_to3");
        // Owner 3 releases but keeps requesting: excluded, goes idle.
        applyStimulus(0, 7'b1000, 1'b1, 7'b0000, 3'd0, 1'b0, 1'b0, "release_exclude");
        applyStimulus(0, 7'b1000, 1'b0, 7'b1000, 3'd3, 1'b1, 1'b0, "regrant3");
        applyStimulus(0, 7'b0000, 1'b0, 7'b0000, 3'd0, 1'b0, 1'b0, "drop3_wrap");

        // Sole requester 2 held 20 cycles: never preempted.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 7'b0100, 1'b0, 7'b0100, 3'd2, 1'b1, 1'b0, "sole_hold2");
        end
        // Requester 0 joins; counter climbs to 7, then release at timeout edge.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 7'b0101, 1'b0, 7'b0100, 3'd2, 1'b1, 1'b0, "contended_hold2");
        end
        applyStimulus(0, 7'b0101, 1'b1, 7'b0001, 3'd0, 1'b1, 1'b0, "release_at_timeout");
        applyStimulus(0, 7'b0000, 1'b0, 7'b0000, 3'd0, 1'b0, 1'b0, "drop0");

        // Owner 3 granted (pointer is 1), then reset mid-cycle.
        applyStimulus(0, 7'b1000, 1'b0, 7'b1000, 3'd3, 1'b1, 1'b0, "grant3_prereset");
        @(posedge clk);
        #4;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 0, 7'h00, 3'd0, 1'b0, 1'b0);
        req4 = 4'b1111;
        rel4 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("held_in_reset", 0, 7'h00, 3'd0, 1'b0, 1'b0);
        req4 = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 7'b1111, 1'b0, 7'b0001, 3'd0, 1'b1, 1'b0, "post_reset_ptr0");
        applyStimulus(0, 7'b0000, 1'b0, 7'b0000, 3'd0, 1'b0, 1'b0, "post_reset_drop");

        // Seven requesters all asking, release every second cycle: owners
        // 0,1,1,2,2,...,6,6,0,0 wrapping over the non-power-of-two count.
        for (int i = 0; i < 15; i++) begin
            own = (i == 0) ? 0 : ((i + 1) / 2) % 7;
            applyStimulus(1, 7'h7F, (i % 2) == 1, 7'(1 << own), 3'(own), 1'b1, 1'b0, "rr7_wrap");
        end
        applyStimulus(1, 7'h00, 1'b0, 7'h00, 3'd0, 1'b0, 1'b0, "rr7_idle");

        // Let the monitor drain, bounded.
        for (int w = 0; w < 10 && sbQueue.size() > 0; w++) begin
            @(posedge clk);
            #3;
        end
        if (sbQueue.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sbQueue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
